vanilla_dual_issue_buffer: RTL and testbench



---
 rtl/vanilla_dual_issue_buffer_pkg.sv | 61 ++++++
 rtl/vanilla_dual_issue_buffer_if.sv | 31 +++
 rtl/vanilla_dual_issue_buffer_classify.sv | 98 +++++++++
 rtl/vanilla_dual_issue_buffer.sv | 136 +++++++++++++
 tb/tb_vanilla_dual_issue_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vanilla_dual_issue_buffer_pkg.sv
// Shared types for the vanilla dual-issue instruction buffer: instruction layout,
// opcode constants and the per-instruction issue summary produced by the classifier.
package vanilla_dual_issue_buffer_pkg;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] op;
    } instruction_s;

    localparam logic [6:0] op_load_c     = 7'b0000011;
    localparam logic [6:0] op_load_fp_c  = 7'b0000111;
    localparam logic [6:0] op_op_imm_c   = 7'b0010011;
    localparam logic [6:0] op_auipc_c    = 7'b0010111;
    localparam logic [6:0] op_store_c    = 7'b0100011;
    localparam logic [6:0] op_store_fp_c = 7'b0100111;
    localparam logic [6:0] op_op_c       = 7'b0110011;
    localparam logic [6:0] op_lui_c      = 7'b0110111;
    localparam logic [6:0] op_fmadd_c    = 7'b1000011;
    localparam logic [6:0] op_fmsub_c    = 7'b1000111;
    localparam logic [6:0] op_fnmsub_c   = 7'b1001011;
    localparam logic [6:0] op_fnmadd_c   = 7'b1001111;
    localparam logic [6:0] op_op_fp_c    = 7'b1010011;
    localparam logic [6:0] op_branch_c   = 7'b1100011;
    localparam logic [6:0] op_jalr_c     = 7'b1100111;
    localparam logic [6:0] op_jal_c      = 7'b1101111;

    // OP-FP funct7 values (single precision) that move data across register files
    localparam logic [6:0] f7_fmv_x_w_c  = 7'b1110000;
    localparam logic [6:0] f7_fcvt_w_s_c = 7'b1100000;
    localparam logic [6:0] f7_fcmp_c     = 7'b1010000;
    localparam logic [6:0] f7_fmv_w_x_c  = 7'b1111000;
    localparam logic [6:0] f7_fcvt_s_w_c = 7'b1101000;
    localparam logic [6:0] f7_fsqrt_c    = 7'b0101100;

    typedef enum logic {e_issue_int, e_issue_fp} issue_class_e;

    typedef struct packed {
        issue_class_e cls;
        logic         is_branch_or_jump;
        logic         rd_int_w;
        logic         rd_fp_w;
        logic         rs1_fp_r;
        logic         rs2_fp_r;
        logic         rs3_fp_r;
        logic         rs1_int_r;
        logic         rs2_int_r;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rs3;
    } issue_info_s;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/vanilla_dual_issue_buffer_if.sv
// Fetch/issue handshake bundle for the dual-issue buffer; slave is the buffer,
// master is the fetch/decode side.
interface vanilla_dual_issue_buffer_if #(parameter int stat_width_p = 32);
    import vanilla_dual_issue_buffer_pkg::*;

    logic                    v_i;
    instruction_s            instr_i;
    logic                    ready_o;
    logic                    flush_i;
    logic                    int_v_o;
    instruction_s            int_instr_o;
    logic                    fp_v_o;
    instruction_s            fp_instr_o;
    logic                    fp_older_o;
    logic                    yumi_i;
    logic [stat_width_p-1:0] dual_count_o;
    logic [stat_width_p-1:0] single_count_o;

    modport slave (
        input  v_i, instr_i, flush_i, yumi_i,
        output ready_o, int_v_o, int_instr_o, fp_v_o, fp_instr_o, fp_older_o,
               dual_count_o, single_count_o
    );

    modport master (
        output v_i, instr_i, flush_i, yumi_i,
        input  ready_o, int_v_o, int_instr_o, fp_v_o, fp_instr_o, fp_older_o,
               dual_count_o, single_count_o
    );

endinterface

// File: rtl/vanilla_dual_issue_buffer_classify.sv
// Decodes one instruction into its issue class and the register-file accesses
// the pairing logic needs to spot intra-pair hazards.
module vanilla_issue_classify
    import vanilla_dual_issue_buffer_pkg::*;
(
    input  instruction_s instr_i,
    output issue_info_s  info_o
);

    always_comb begin
        info_o     = '0;
        info_o.cls = e_issue_int;
        info_o.rd  = instr_i.rd;
        info_o.rs1 = instr_i.rs1;
        info_o.rs2 = instr_i.rs2;
        info_o.rs3 = instr_i.funct7[6:2];

        case (instr_i.op)
            op_lui_c, op_auipc_c: info_o.rd_int_w = 1'b1;
            op_jal_c: begin
                info_o.rd_int_w          = 1'b1;
                info_o.is_branch_or_jump = 1'b1;
            end
            op_jalr_c: begin
                info_o.rd_int_w          = 1'b1;
                info_o.rs1_int_r         = 1'b1;
                info_o.is_branch_or_jump = 1'b1;
            end
            op_branch_c: begin
                info_o.rs1_int_r         = 1'b1;
                info_o.rs2_int_r         = 1'b1;
                info_o.is_branch_or_jump = 1'b1;
            end
            op_load_c, op_op_imm_c: begin
                info_o.rd_int_w  = 1'b1;
                info_o.rs1_int_r = 1'b1;
            end
            op_store_c: begin
                info_o.rs1_int_r = 1'b1;
                info_o.rs2_int_r = 1'b1;
            end
            op_op_c: begin
                info_o.rd_int_w  = 1'b1;
                info_o.rs1_int_r = 1'b1;
                info_o.rs2_int_r = 1'b1;
            end
            op_load_fp_c: begin
                info_o.rs1_int_r = 1'b1;
                info_o.rd_fp_w   = (instr_i.funct3 == 3'b010);
            end
            op_store_fp_c: begin
                info_o.rs1_int_r = 1'b1;
                info_o.rs2_fp_r  = (instr_i.funct3 == 3'b010);
            end
            op_fmadd_c, op_fmsub_c, op_fnmsub_c, op_fnmadd_c: begin
                info_o.cls      = e_issue_fp;
                info_o.rd_fp_w  = 1'b1;
                info_o.rs1_fp_r = 1'b1;
                info_o.rs2_fp_r = 1'b1;
                info_o.rs3_fp_r = 1'b1;
            end
            op_op_fp_c: begin
                info_o.cls = e_issue_fp;
                case (instr_i.funct7)
                    f7_fmv_x_w_c, f7_fcvt_w_s_c: begin
                        info_o.rd_int_w = 1'b1;
                        info_o.rs1_fp_r = 1'b1;
                    end
                    f7_fcmp_c: begin
                        info_o.rd_int_w = 1'b1;
                        info_o.rs1_fp_r = 1'b1;
                        info_o.rs2_fp_r = 1'b1;
                    end
                    f7_fmv_w_x_c, f7_fcvt_s_w_c: begin
                        info_o.rd_fp_w   = 1'b1;
                        info_o.rs1_int_r = 1'b1;
                    end
                    f7_fsqrt_c: begin
                        info_o.rd_fp_w  = 1'b1;
                        info_o.rs1_fp_r = 1'b1;
                    end
                    default: begin
                        info_o.rd_fp_w  = 1'b1;
                        info_o.rs1_fp_r = 1'b1;
                        info_o.rs2_fp_r = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase

        // x0 is never a real dependency on the integer side
        info_o.rd_int_w  = info_o.rd_int_w  & (instr_i.rd  != 5'd0);
        info_o.rs1_int_r = info_o.rs1_int_r & (instr_i.rs1 != 5'd0);
        info_o.rs2_int_r = info_o.rs2_int_r & (instr_i.rs2 != 5'd0);
    end

endmodule

// File: rtl/vanilla_dual_issue_buffer.sv
// Fetch-to-decode instruction buffer that issues one instruction, or an int/fp pair.
// Define BSG_VANILLA_DUAL_ISSUE_STATS_EN to build the single/dual issue counters.
module vanilla_dual_issue_buffer
    import vanilla_dual_issue_buffer_pkg::*;
#(
    parameter int els_p        = 4,
    parameter int stat_width_p = 32
) (
    input logic                         clk_i,
    input logic                         reset_i,
    vanilla_dual_issue_buffer_if.slave  bus
);

    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

    instruction_s          mem_r [els_p];
    logic [ptr_w_lp-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_p1, rd_ptr_p2;
    logic [cnt_w_lp-1:0]   count_r;
    instruction_s          h_instr, n_instr;
    issue_info_s           h_info, n_info, i_info, f_info;
    logic                  fp_is_h, hazard, dual, has_one, has_two;
    logic                  ready, enq, consume;
    logic                  haz_flw, haz_fsw, haz_xrd, haz_war;
    logic [1:0]            deq_n;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    assign rd_ptr_p1 = ptr_inc(rd_ptr_r);
    assign rd_ptr_p2 = ptr_inc(rd_ptr_p1);
    assign h_instr   = mem_r[rd_ptr_r];
    assign n_instr   = mem_r[rd_ptr_p1];

    vanilla_issue_classify classify_h (.instr_i(h_instr), .info_o(h_info));
    vanilla_issue_classify classify_n (.instr_i(n_instr), .info_o(n_info));

    // Hazard terms are evaluated on the int/fp view of the pair, whichever is older
    assign fp_is_h = (h_info.cls == e_issue_fp);
    assign i_info  = fp_is_h ? n_info : h_info;
    assign f_info  = fp_is_h ? h_info : n_info;

    assign haz_flw = i_info.rd_fp_w
                   & ((f_info.rs1_fp_r & (f_info.rs1 == i_info.rd))
                    | (f_info.rs2_fp_r & (f_info.rs2 == i_info.rd))
                    | (f_info.rs3_fp_r & (f_info.rs3 == i_info.rd))
                    | (f_info.rd_fp_w  & (f_info.rd  == i_info.rd)));
    assign haz_fsw = f_info.rd_fp_w & i_info.rs2_fp_r & (i_info.rs2 == f_info.rd);
    assign haz_xrd = f_info.rd_int_w
                   & ((i_info.rs1_int_r & (i_info.rs1 == f_info.rd))
                    | (i_info.rs2_int_r & (i_info.rs2 == f_info.rd))
                    | (i_info.rd_int_w  & (i_info.rd  == f_info.rd)));
    assign haz_war = ~fp_is_h & f_info.rd_fp_w
                   & ((i_info.rs1_fp_r & (i_info.rs1 == f_info.rd))
                    | (i_info.rs2_fp_r & (i_info.rs2 == f_info.rd)));
    assign hazard  = haz_flw | haz_fsw | haz_xrd | haz_war;

    assign has_one = (count_r != '0);
    assign has_two = (count_r >= cnt_w_lp'(2));
    assign dual    = has_two & (h_info.cls != n_info.cls)
                   & ~n_info.is_branch_or_jump & ~hazard;

    assign bus.int_v_o     = has_one & (dual | ~fp_is_h);
    assign bus.fp_v_o      = has_one & (dual | fp_is_h);
    assign bus.fp_older_o  = dual & fp_is_h;
    assign bus.int_instr_o = (dual & fp_is_h)  ? n_instr : h_instr;
    assign bus.fp_instr_o  = (dual & ~fp_is_h) ? n_instr : h_instr;

    assign ready       = (count_r != full_cnt_lp);
    assign bus.ready_o = ready;
    assign enq         = bus.v_i & ready & ~bus.flush_i;
    assign consume     = bus.yumi_i & has_one;
    assign deq_n       = ~consume ? 2'd0 : (dual ? 2'd2 : 2'd1);

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wr_ptr_r] <= bus.instr_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (bus.flush_i) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            case (deq_n)
                2'd1:    rd_ptr_r <= rd_ptr_p1;
                2'd2:    rd_ptr_r <= rd_ptr_p2;
                default: rd_ptr_r <= rd_ptr_r;
            endcase
            count_r <= count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq_n);
        end
    end

`ifdef BSG_VANILLA_DUAL_ISSUE_STATS_EN
    logic [stat_width_p-1:0] dual_cnt_r, single_cnt_r;

    // Consumption is counted even in a flush cycle; saturate instead of wrapping
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dual_cnt_r   <= '0;
            single_cnt_r <= '0;
        end else if (consume) begin
            if (dual && !(&dual_cnt_r)) begin
                dual_cnt_r <= dual_cnt_r + 1'b1;
            end
            if (!dual && !(&single_cnt_r)) begin
                single_cnt_r <= single_cnt_r + 1'b1;
            end
        end
    end

    assign bus.dual_count_o   = dual_cnt_r;
    assign bus.single_count_o = single_cnt_r;
`else
    assign bus.dual_count_o   = '0;
    assign bus.single_count_o = '0;
`endif

`ifndef SYNTHESIS
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.yumi_i |-> (bus.int_v_o | bus.fp_v_o))
        else $error("yumi_i asserted with no valid issue slot");
`endif

endmodule

// File: tb/tb_vanilla_dual_issue_buffer.sv
// Directed bench for vanilla_dual_issue_buffer with a queue-based reference model
// checked every cycle, plus hand-computed expectations for key scenarios.
module tb_vanilla_dual_issue_buffer;
    import vanilla_dual_issue_buffer_pkg::*;

    localparam int ELS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   run_chk = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    instruction_s q[$];
    int unsigned  m_dual = 0;
    int unsigned  m_single = 0;

    vanilla_dual_issue_buffer_if #(.stat_width_p(32)) bus ();

    vanilla_dual_issue_buffer #(.els_p(ELS), .stat_width_p(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instruction_s enc(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
        instruction_s r;
        r.funct7 = f7; r.rs2 = rs2; r.rs1 = rs1; r.funct3 = f3; r.rd = rd; r.op = op;
        return r;
    endfunction

    // Register-file footprint of an instruction as read/write sets
    function automatic void footprint(input instruction_s i, output bit fp, output bit bj,
                                      output int fpw, output int intw,
                                      output logic [31:0] fpr, output logic [31:0] intr);
        fp   = i.op inside {op_op_fp_c, op_fmadd_c, op_fmsub_c, op_fnmsub_c, op_fnmadd_c};
        bj   = i.op inside {op_branch_c, op_jal_c, op_jalr_c};
        fpw  = -1; intw = -1; fpr = '0; intr = '0;
        case (i.op)
            op_lui_c, op_auipc_c, op_jal_c: intw = i.rd;
            op_jalr_c, op_load_c, op_op_imm_c: begin intw = i.rd; intr[i.rs1] = 1'b1; end
            op_op_c: begin intw = i.rd; intr[i.rs1] = 1'b1; intr[i.rs2] = 1'b1; end
            op_branch_c, op_store_c: begin intr[i.rs1] = 1'b1; intr[i.rs2] = 1'b1; end
            op_load_fp_c: begin fpw = i.rd; intr[i.rs1] = 1'b1; end
            op_store_fp_c: begin intr[i.rs1] = 1'b1; fpr[i.rs2] = 1'b1; end
            op_fmadd_c, op_fmsub_c, op_fnmsub_c, op_fnmadd_c: begin
                fpw = i.rd; fpr[i.rs1] = 1'b1; fpr[i.rs2] = 1'b1; fpr[i.funct7[6:2]] = 1'b1;
            end
            op_op_fp_c: begin
                case (i.funct7)
                    7'b1110000, 7'b1100000: begin intw = i.rd; fpr[i.rs1] = 1'b1; end
                    7'b1010000: begin intw = i.rd; fpr[i.rs1] = 1'b1; fpr[i.rs2] = 1'b1; end
                    7'b1111000, 7'b1101000: begin fpw = i.rd; intr[i.rs1] = 1'b1; end
                    7'b0101100: begin fpw = i.rd; fpr[i.rs1] = 1'b1; end
                    default: begin fpw = i.rd; fpr[i.rs1] = 1'b1; fpr[i.rs2] = 1'b1; end
                endcase
            end
            default: ;
        endcase
        intr[0] = 1'b0;
        if (intw == 0) intw = -1;
    endfunction

    function automatic bit model_dual();
        bit hfp, hbj, nfp, nbj, haz;
        int hfw, hiw, nfw, niw, ifw, iiw, ffw, fiw;
        logic [31:0] hfr, hir, nfr, nir, ifr, iir, ffr;
        if (q.size() < 2) return 1'b0;
        footprint(q[0], hfp, hbj, hfw, hiw, hfr, hir);
        footprint(q[1], nfp, nbj, nfw, niw, nfr, nir);
        if (hfp == nfp || nbj) return 1'b0;
        if (hfp) begin ifw = nfw; iiw = niw; ifr = nfr; iir = nir; ffw = hfw; fiw = hiw; ffr = hfr; end
        else     begin ifw = hfw; iiw = hiw; ifr = hfr; iir = hir; ffw = nfw; fiw = niw; ffr = nfr; end
        haz = (ifw >= 0 && (ffr[ifw] || ffw == ifw))
           || (ffw >= 0 && ifr[ffw])
           || (fiw >= 0 && (iir[fiw] || iiw == fiw));
        return !haz;
    endfunction

    function automatic void predict(output bit iv, output bit fv, output bit older,
                                    output instruction_s ii, output instruction_s fi);
        bit d, hfp, bj;
        int a, b;
        logic [31:0] c, e;
        iv = 0; fv = 0; older = 0; ii = '0; fi = '0;
        if (q.size() == 0) return;
        d = model_dual();
        footprint(q[0], hfp, bj, a, b, c, e);
        if (!d) begin
            if (hfp) begin fv = 1; fi = q[0]; end
            else     begin iv = 1; ii = q[0]; end
        end else begin
            iv = 1; fv = 1; older = hfp;
            ii = hfp ? q[1] : q[0];
            fi = hfp ? q[0] : q[1];
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_dual   = 0;
            m_single = 0;
        end else begin
            int  n;
            bit  rdy;
            rdy = (q.size() < ELS);
            n   = (bus.yumi_i && q.size() > 0) ? (model_dual() ? 2 : 1) : 0;
            if (n == 2) m_dual++;
            else if (n == 1) m_single++;
            if (bus.flush_i) q.delete();
            else begin
                repeat (n) void'(q.pop_front());
                if (bus.v_i && rdy) q.push_back(bus.instr_i);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && run_chk) begin
            bit iv, fv, older;
            instruction_s ii, fi;
            predict(iv, fv, older, ii, fi);
            check("ready_o", bus.ready_o, q.size() < ELS);
            check("int_v_o", bus.int_v_o, iv);
            check("fp_v_o", bus.fp_v_o, fv);
            if (q.size() > 0) check("fp_older_o", bus.fp_older_o, older);
            if (iv) check("int_instr_o", bus.int_instr_o, ii);
            if (fv) check("fp_instr_o", bus.fp_instr_o, fi);
`ifdef BSG_VANILLA_DUAL_ISSUE_STATS_EN
            check("dual_count_o", bus.dual_count_o, m_dual);
            check("single_count_o", bus.single_count_o, m_single);
`else
            check("dual_count_o", bus.dual_count_o, 0);
            check("single_count_o", bus.single_count_o, 0);
`endif
        end
    end

    task automatic set_in(input bit v, input instruction_s ins, input bit fl, input bit yu);
        bus.v_i     = v;
        bus.instr_i = ins;
        bus.flush_i = fl;
        bus.yumi_i  = yu && (q.size() > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input instruction_s ins, input bit fl, input bit yu);
        set_in(v, ins, fl, yu);
        tick();
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 8 && q.size() > 0; k++) step(0, '0, 0, 1);
        set_in(0, '0, 0, 0);
        check(name, {bus.int_v_o, bus.fp_v_o}, 2'b00);
    endtask

    instruction_s add_a, add_b, fadd, beq, addi, flw, fadd_dep, fmul, lw, fsw, fmvxw, add_dep;
    instruction_s fmadd, fadd_f1, fsw_f1, addi_z, addi_w;

    initial begin
        add_a    = enc(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, op_op_c);
        add_b    = enc(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd4, op_op_c);
        fadd     = enc(7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, op_op_fp_c);
        beq      = enc(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, op_branch_c);
        addi     = enc(7'b0000000, 5'd5, 5'd0, 3'b000, 5'd1, op_op_imm_c);
        flw      = enc(7'b0000000, 5'd0, 5'd1, 3'b010, 5'd3, op_load_fp_c);
        fadd_dep = enc(7'b0000000, 5'd5, 5'd3, 3'b000, 5'd4, op_op_fp_c);
        fmul     = enc(7'b0001000, 5'd8, 5'd7, 3'b000, 5'd6, op_op_fp_c);
        lw       = enc(7'b0000000, 5'd0, 5'd2, 3'b010, 5'd5, op_load_c);
        fsw      = enc(7'b0000000, 5'd9, 5'd2, 3'b010, 5'd0, op_store_fp_c);
        fmvxw    = enc(7'b1110000, 5'd0, 5'd1, 3'b000, 5'd7, op_op_fp_c);
        add_dep  = enc(7'b0000000, 5'd1, 5'd7, 3'b000, 5'd8, op_op_c);
        fmadd    = enc({5'd3, 2'b00}, 5'd2, 5'd1, 3'b000, 5'd9, op_fmadd_c);
        fadd_f1  = enc(7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, op_op_fp_c);
        fsw_f1   = enc(7'b0000000, 5'd1, 5'd2, 3'b010, 5'd0, op_store_fp_c);
        addi_z   = enc(7'b0000000, 5'd9, 5'd0, 3'b000, 5'd10, op_op_imm_c);
        addi_w   = enc(7'b0000000, 5'd7, 5'd0, 3'b000, 5'd11, op_op_imm_c);

        set_in(0, '0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_chk = 1'b1;

        // reset state
        check("rst_int_v", bus.int_v_o, 1'b0);
        check("rst_fp_v", bus.fp_v_o, 1'b0);
        check("rst_ready", bus.ready_o, 1'b1);
        check("rst_dual_cnt", bus.dual_count_o, 32'd0);
        check("rst_single_cnt", bus.single_count_o, 32'd0);

        // streamed ADD, ADD, FADD.S, BEQ: never two entries buffered -> all single
        step(1, add_a, 0, 0);
        step(1, add_b, 0, 1);
        step(1, fadd, 0, 1);
        step(1, beq, 0, 1);
        step(0, '0, 0, 1);
        set_in(0, '0, 0, 0);
`ifdef BSG_VANILLA_DUAL_ISSUE_STATS_EN
        check("stream_single_cnt", bus.single_count_o, 32'd4);
`else
        check("stream_single_cnt", bus.single_count_o, 32'd0);
`endif
        check("stream_dual_cnt", bus.dual_count_o, 32'd0);

        // ADDI then FADD.S -> dual, int older
        step(1, addi, 0, 0);
        set_in(1, fadd, 0, 0);
        check("t1_single_head", {bus.int_v_o, bus.fp_v_o}, 2'b10);
        tick();
        set_in(0, '0, 0, 1);
        check("t1_dual_valid", {bus.int_v_o, bus.fp_v_o, bus.fp_older_o}, 3'b110);
        check("t1_int_instr", bus.int_instr_o, addi);
        check("t1_fp_instr", bus.fp_instr_o, fadd);
        tick();
        drain("t1_empty");

        // FLW f3 then FADD.S f4,f3,f5 -> serialised
        step(1, flw, 0, 0);
        step(1, fadd_dep, 0, 0);
        set_in(0, '0, 0, 1);
        check("t2_flw_alone", {bus.int_v_o, bus.fp_v_o}, 2'b10);
        check("t2_flw_instr", bus.int_instr_o, flw);
        tick();
        set_in(0, '0, 0, 1);
        check("t2_fadd_alone", {bus.int_v_o, bus.fp_v_o}, 2'b01);
        tick();
        drain("t2_empty");

        // fill to full, then v_i with yumi_i on a full buffer
        step(1, add_a, 0, 0);
        step(1, add_b, 0, 0);
        step(1, addi, 0, 0);
        step(1, lw, 0, 0);
        set_in(1, addi_z, 0, 1);
        check("t3_full_ready", bus.ready_o, 1'b0);
        tick();
        set_in(0, '0, 0, 0);
        check("t3_ready_after", bus.ready_o, 1'b1);
        check("t3_head_after", bus.int_instr_o, add_b);
        drain("t3_empty");

        // walk pointers to entry 3, then FMUL.S/LW pair across the wrap
        step(1, addi, 0, 0);
        step(1, add_a, 0, 1);
        step(1, add_b, 0, 1);
        step(0, '0, 0, 1);
        step(1, fmul, 0, 0);
        step(1, lw, 0, 0);
        set_in(0, '0, 0, 1);
        check("t4_wrap_dual", {bus.int_v_o, bus.fp_v_o, bus.fp_older_o}, 3'b111);
        check("t4_wrap_fp", bus.fp_instr_o, fmul);
        check("t4_wrap_int", bus.int_instr_o, lw);
        tick();
        set_in(0, '0, 0, 0);
        check("t4_wrap_empty", {bus.int_v_o, bus.fp_v_o}, 2'b00);

        // flush with three entries, concurrent enqueue and yumi
        step(1, add_a, 0, 0);
        step(1, fsw, 0, 0);
        step(1, fmul, 0, 0);
        step(1, addi_z, 1, 1);
        set_in(0, '0, 0, 0);
        check("t5_flush_valid", {bus.int_v_o, bus.fp_v_o}, 2'b00);
        check("t5_flush_ready", bus.ready_o, 1'b1);
        step(1, addi_w, 0, 0);
        set_in(0, '0, 0, 0);
        check("t5_fresh_head", bus.int_instr_o, addi_w);
        check("t5_fresh_alone", {bus.int_v_o, bus.fp_v_o}, 2'b10);
        drain("t5_empty");

        // hazard and pairing cases
        step(1, fmvxw, 0, 0);
        step(1, add_dep, 0, 0);
        set_in(0, '0, 0, 0);
        check("t6_fmv_x_haz", {bus.int_v_o, bus.fp_v_o}, 2'b01);
        drain("t6_fmv_empty");

        step(1, fadd_f1, 0, 0);
        step(1, fsw_f1, 0, 0);
        set_in(0, '0, 0, 0);
        check("t6_fsw_haz", {bus.int_v_o, bus.fp_v_o}, 2'b01);
        drain("t6_fsw_empty");

        step(1, fmadd, 0, 0);
        step(1, add_a, 0, 0);
        set_in(0, '0, 0, 0);
        check("t6_fmadd_dual", {bus.int_v_o, bus.fp_v_o, bus.fp_older_o}, 3'b111);
        drain("t6_fmadd_empty");

        step(1, fadd, 0, 0);
        step(1, beq, 0, 0);
        set_in(0, '0, 0, 0);
        check("t6_branch_second", {bus.int_v_o, bus.fp_v_o}, 2'b01);
        drain("t6_br2_empty");

        step(1, beq, 0, 0);
        step(1, fadd, 0, 0);
        set_in(0, '0, 0, 0);
        check("t6_branch_first", {bus.int_v_o, bus.fp_v_o, bus.fp_older_o}, 3'b110);
        drain("t6_br1_empty");

        // mixed burst through the model
        step(1, add_a, 0, 0);
        step(1, fmul, 0, 0);
        step(1, flw, 0, 1);
        step(1, fadd_dep, 0, 1);
        step(1, lw, 0, 1);
        step(1, fmadd, 0, 1);
        drain("t7_empty");

        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
